ysyx_22041211_alu_mdu: RTL and testbench

//  Parametrised execute unit: registered base-integer ALU plus iterative RV32M mul/div/rem.

---
 rtl/ysyx_22041211_alu_mdu.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_22041211_alu_mdu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_alu_mdu.sv
// ysyx_22041211_alu_mdu: registered base-integer ALU plus iterative RV32M mul/div/rem.
// One op in flight; the shift-add multiplier and restoring divider share one step counter.
module ysyx_22041211_alu_mdu #(
  parameter int DATA_LEN = 32,
  parameter int SHAMT_W  = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  input  logic [4:0]          alu_control,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] result,
  output logic                busy
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(DATA_LEN - 1);
  localparam logic [DATA_LEN-1:0] MIN_VAL   = {1'b1, {(DATA_LEN-1){1'b0}}};

  function automatic logic [DATA_LEN-1:0] magnitude(input logic [DATA_LEN-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [DATA_LEN-1:0] base_op(input logic [4:0] op,
                                                  input logic [DATA_LEN-1:0] a,
                                                  input logic [DATA_LEN-1:0] b);
    logic [DATA_LEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << b[SHAMT_W-1:0];
      OP_SLT:  r[0] = $signed(a) < $signed(b);
      OP_SLTU: r[0] = a < b;
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> b[SHAMT_W-1:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]            state_r;
  logic [4:0]            op_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [2*DATA_LEN-1:0] mcand_r;
  logic [DATA_LEN-1:0]   mplier_r;
  logic [2*DATA_LEN-1:0] prod_r;
  logic [DATA_LEN-1:0]   dvs_r;
  logic [DATA_LEN-1:0]   quo_r;
  logic [DATA_LEN-1:0]   rem_r;
  logic                  neg_q_r;
  logic                  neg_r_r;
  logic [DATA_LEN-1:0]   result_r;

  logic                  is_mul_s, is_div_s, neg1_s, neg2_s;
  logic                  div_zero_s, div_ovf_s;
  logic [DATA_LEN-1:0]   special_s;
  logic [DATA_LEN-1:0]   mag1_s, mag2_s;

  // Decode the op presented in IDLE: class, operand signs and divide special cases.
  always_comb begin
    is_mul_s   = alu_control inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div_s   = alu_control inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    neg1_s     = (alu_control inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src1[DATA_LEN-1];
    neg2_s     = (alu_control inside {OP_MULH, OP_DIV, OP_REM}) && src2[DATA_LEN-1];
    mag1_s     = magnitude(src1, neg1_s);
    mag2_s     = magnitude(src2, neg2_s);
    div_zero_s = is_div_s && (src2 == '0);
    div_ovf_s  = (alu_control inside {OP_DIV, OP_REM}) && (src1 == MIN_VAL) && (src2 == '1);
    case (alu_control)
      OP_DIV:  special_s = div_zero_s ? '1 : MIN_VAL;
      OP_DIVU: special_s = '1;
      OP_REM:  special_s = div_zero_s ? src1 : '0;
      OP_REMU: special_s = src1;
      default: special_s = '0;
    endcase
  end

  logic [2*DATA_LEN-1:0] prod_next_s, prod_fin_s;
  logic [DATA_LEN:0]     trial_s;
  logic [DATA_LEN-1:0]   quo_next_s, rem_next_s, quo_fin_s, rem_fin_s;
  logic [DATA_LEN-1:0]   mul_res_s, div_res_s;

  // One iteration step of each engine, plus sign correction of the final step.
  always_comb begin
    prod_next_s = prod_r + (mplier_r[0] ? mcand_r : '0);
    prod_fin_s  = neg_q_r ? -prod_next_s : prod_next_s;
    mul_res_s   = (op_r == OP_MUL) ? prod_fin_s[DATA_LEN-1:0] : prod_fin_s[2*DATA_LEN-1:DATA_LEN];
    // The partial remainder stays below the divisor, so one extra bit holds the trial sign.
    trial_s     = {rem_r, quo_r[DATA_LEN-1]} - {1'b0, dvs_r};
    quo_next_s  = {quo_r[DATA_LEN-2:0], ~trial_s[DATA_LEN]};
    if (trial_s[DATA_LEN]) begin
      rem_next_s = {rem_r[DATA_LEN-2:0], quo_r[DATA_LEN-1]};
    end else begin
      rem_next_s = trial_s[DATA_LEN-1:0];
    end
    quo_fin_s = neg_q_r ? -quo_next_s : quo_next_s;
    rem_fin_s = neg_r_r ? -rem_next_s : rem_next_s;
    div_res_s = (op_r inside {OP_DIV, OP_DIVU}) ? quo_fin_s : rem_fin_s;
  end

  // Control FSM, operand latching and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= 5'd0;
      cnt_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      prod_r   <= '0;
      dvs_r    <= '0;
      quo_r    <= '0;
      rem_r    <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r  <= alu_control;
            cnt_r <= '0;
            if (is_mul_s) begin
              mcand_r  <= {{DATA_LEN{1'b0}}, mag1_s};
              mplier_r <= mag2_s;
              prod_r   <= '0;
              neg_q_r  <= neg1_s ^ neg2_s;
              state_r  <= MUL;
            end else if (is_div_s && !div_zero_s && !div_ovf_s) begin
              dvs_r   <= mag2_s;
              quo_r   <= mag1_s;
              rem_r   <= '0;
              neg_q_r <= neg1_s ^ neg2_s;
              neg_r_r <= neg1_s;
              state_r <= DIV;
            end else begin
              result_r <= is_div_s ? special_s : base_op(alu_control, src1, src2);
              state_r  <= DONE;
            end
          end
        end
        MUL: begin
          mcand_r  <= {mcand_r[2*DATA_LEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[DATA_LEN-1:1]};
          prod_r   <= prod_next_s;
          if (cnt_r == LAST_STEP) begin
            cnt_r    <= '0;
            result_r <= mul_res_s;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DIV: begin
          quo_r <= quo_next_s;
          rem_r <= rem_next_s;
          if (cnt_r == LAST_STEP) begin
            cnt_r    <= '0;
            result_r <= div_res_s;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == MUL) || (state_r == DIV);
  assign result    = result_r;

endmodule

// File: tb/tb_ysyx_22041211_alu_mdu.sv
// Bench for ysyx_22041211_alu_mdu: directed and random ops through a result/latency scoreboard,
// plus output stall and mid-divide reset.
module tb_ysyx_22041211_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_22041211_alu_mdu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model built on native SystemVerilog arithmetic.
  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa = a; sb = b; r = 32'h0; p = 64'h0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = {31'h0, sa < sb};
      5'd4:  r = {31'h0, a < b};
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $unsigned(sa >>> b[4:0]);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      5'd11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      5'd12: begin p = {{32{a[31]}}, a} * {32'h0, b}; r = p[63:32]; end
      5'd13: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      5'd14: r = (b == 32'h0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned(sa / sb);
      5'd15: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      5'd16: r = (b == 32'h0) ? a : ovf ? 32'h0 : $unsigned(sa % sb);
      5'd17: r = (b == 32'h0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) return 33;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 32'h0) return 1;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Issue one op, hold garbage on the inputs while it runs, then retire it through the scoreboard.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int stall);
    int cyc;
    int lat;
    logic [31:0] e;
    int l;
    lat = ref_lat(op, a, b);
    @(negedge clk);
    check_val({tag, "_rdy"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; src1 = a; src2 = b; alu_control = op;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    src1 = $urandom; src2 = $urandom; alu_control = 5'($urandom_range(0, 17));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && lat > 1) check_val({tag, "_busy"}, 64'(busy), 64'(1));
    end while (!out_valid && cyc < 100);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check_val({tag, "_lat"}, 64'(cyc), 64'(l));
    check_val(tag, 64'(result), 64'(e));
    check_val({tag, "_nrdy"}, 64'(in_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val({tag, "_hold"}, 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, e}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int stray;
    logic [4:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = 32'h0; src2 = 32'h0; alu_control = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_val("reset_state", 64'({in_ready, out_valid, busy, result}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));

    run_op("or",      5'd8,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0);
    run_op("sra33",   5'd7,  32'h8000_0000, 32'd33,        32'hC000_0000, 0);
    run_op("slt",     5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
    run_op("sltu",    5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    run_op("sub_wrap",5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    run_op("mul",     5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("mulhu",   5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulh",    5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhsu",  5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div",     5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
    run_op("rem",     5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op("divu",    5'd15, 32'd100,       32'd7,         32'd14,        0);
    run_op("remu",    5'd17, 32'd100,       32'd7,         32'd2,         0);
    run_op("divu_z",  5'd15, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 0);
    run_op("rem_z",   5'd16, 32'd5,         32'h0,         32'd5,         0);
    run_op("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("bad_op",  5'd25, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 0);

    run_op("stall",   5'd0,  32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 10);
    run_op("after",   5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 18));
      if (op == 5'd18) op = 5'd30;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      run_op("rand", op, a, b, ref_op(op, a, b), 0);
    end

    // Reset in the middle of a divide must drop it without output.
    @(negedge clk);
    in_valid = 1'b1; src1 = 32'hFFFF_FF9C; src2 = 32'd7; alu_control = 5'd14;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_mid", 64'({in_ready, out_valid, busy, result}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    stray = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check_val("no_stray", 64'(stray), 64'(0));
    run_op("post_rst", 5'd15, 32'd100, 32'd7, 32'd14, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
